// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I multi-cycle sequencer:
//   seq_state_e  - sequencer state encoding (3 bits, FETCH..ERR)
//   WBSEL_*      - writeback-select codes produced by control_unit
//   ADDR_SEL_*   - memory address source select values
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } seq_state_e;

  localparam logic [1:0] WBSEL_MEM = 2'b00;
  localparam logic [1:0] WBSEL_ALU = 2'b01;
  localparam logic [1:0] WBSEL_PC  = 2'b11;

  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

endpackage

// File: rtl/riscv_mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// riscv_mc_sequencer_if
// Shared memory-port handshake between the sequencer and the memory.
//   mem_req      request (sequencer -> memory)
//   mem_we       write enable, valid with mem_req
//   mem_addr_sel 0 = pc (fetch), 1 = alu result (data access)
//   mem_ack      request completed (memory -> sequencer)
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface riscv_mc_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/riscv_mc_sequencer_seq_timeout_ctr.sv
// ---------------------------------------------------------------------------
// seq_timeout_ctr
// Memory wait counter with expiry flag. Only built when SEQ_MEM_TIMEOUT_EN is
// defined; the default build has no counter logic at all.
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   wait_i       sequencer is in a memory-request state (FETCH or MEM)
//   ack_i        memory acknowledge
//   expired_o    limit reached this cycle with no ack
// ---------------------------------------------------------------------------
`ifdef SEQ_MEM_TIMEOUT_EN
module seq_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYC) + 1;

  logic [W-1:0] cnt_q;

  // Any cycle outside a request state, or any ack, restarts the count, so
  // the counter is already zero on entry to FETCH or MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!wait_i || ack_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = wait_i && !ack_i && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/riscv_mc_sequencer.sv
// ---------------------------------------------------------------------------
// riscv_mc_sequencer
// Multi-cycle sequencer for the RV32I datapath. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, shares one memory port between fetch and
// load/store, gates register/memory writes to their own phase and counts
// retired instructions.
// Optional feature macro: SEQ_MEM_TIMEOUT_EN (memory wait timeout -> ERR).
// Ports:
//   clk, rst       clock / asynchronous active-high reset
//   mem            memory handshake (master modport)
//   dec_regwen     regwen from control_unit
//   dec_memw       memw (store) from control_unit
//   dec_wbsel      wbsel from control_unit (00 mem, 01 alu, 11 pc+4)
//   dec_illegal    opcode not decoded
//   ir_we          load instruction register
//   pc_we          update pc
//   rf_we          register-file write enable
//   halted         sticky illegal-instruction flag
//   err            sticky memory timeout flag (0 without the macro)
//   instret        retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module riscv_mc_sequencer
  import riscv_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mc_sequencer_if.master  mem,
  input  logic                  dec_regwen,
  input  logic                  dec_memw,
  input  logic [1:0]            dec_wbsel,
  input  logic                  dec_illegal,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  rf_we,
  output logic                  halted,
  output logic                  err,
  output logic [CNT_W-1:0]      instret
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             req, we, addr_sel, ir_we_c, pc_we_c, rf_we_c, retire;
  logic             expired;

`ifdef SEQ_MEM_TIMEOUT_EN
  logic waiting;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);

  seq_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .wait_i    (waiting),
    .ack_i     (mem.mem_ack),
    .expired_o (expired)
  );
  assign err = (state_q == S_ERR);
`else
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    we       = 1'b0;
    addr_sel = ADDR_SEL_PC;
    ir_we_c  = 1'b0;
    pc_we_c  = 1'b0;
    rf_we_c  = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        req     = 1'b1;
        ir_we_c = mem.mem_ack;
        // An ack on the limit cycle takes priority over the timeout.
        if (mem.mem_ack)  state_d = S_DECODE;
        else if (expired) state_d = S_ERR;
      end
      S_DECODE: state_d = dec_illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (dec_memw || (dec_regwen && dec_wbsel == WBSEL_MEM)) state_d = S_MEM;
        else                                                     state_d = S_WB;
      end
      S_MEM: begin
        req      = 1'b1;
        addr_sel = ADDR_SEL_ALU;
        we       = dec_memw;
        if (mem.mem_ack) begin
          // Stores retire on the ack; loads still need the WB cycle.
          if (dec_memw) begin
            pc_we_c = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        rf_we_c = dec_regwen;
        pc_we_c = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = state_q; // HALT and ERR are sticky until reset
    endcase
    // While reset is held the port is quiet even though the state reads FETCH.
    if (rst) begin
      req     = 1'b0;
      we      = 1'b0;
      ir_we_c = 1'b0;
      pc_we_c = 1'b0;
      rf_we_c = 1'b0;
      retire  = 1'b0;
    end
  end

  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_sel = addr_sel;
  assign ir_we            = ir_we_c;
  assign pc_we            = pc_we_c;
  assign rf_we            = rf_we_c;
  assign halted           = (state_q == S_HALT);
  assign instret          = instret_q;

endmodule
